// File: rtl/shift_arbiter_4bit_if.sv
// Request/result bus for shift_arbiter_4bit: two requester ports, one result port, and completion counters.
interface shift_arbiter_4bit_if #(
    parameter int CNT_W = 8
);
    logic             req0_valid;
    logic             req0_ready;
    logic [3:0]       req0_a;
    logic [3:0]       req0_b;
    logic [1:0]       req0_sel;
    logic             req1_valid;
    logic             req1_ready;
    logic [3:0]       req1_a;
    logic [3:0]       req1_b;
    logic [1:0]       req1_sel;
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       out_data;
    logic             out_id;
    logic [CNT_W-1:0] cnt0;
    logic [CNT_W-1:0] cnt1;

    modport master (
        output req0_valid, req0_a, req0_b, req0_sel,
        output req1_valid, req1_a, req1_b, req1_sel,
        output out_ready,
        input  req0_ready, req1_ready, out_valid, out_data, out_id, cnt0, cnt1
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_sel,
        input  req1_valid, req1_a, req1_b, req1_sel,
        input  out_ready,
        output req0_ready, req1_ready, out_valid, out_data, out_id, cnt0, cnt1
    );
endinterface

// File: rtl/shift_arbiter_4bit.sv
// Two-port arbiter sharing one 4-bit shifter, with a single-entry result register.
//   state    | meaning
//   ST_EMPTY | result register holds nothing, any granted request is accepted
//   ST_FULL  | result register valid, accept only when the consumer drains this cycle
module shift_arbiter_4bit #(
    parameter int ARB_MODE = 0,
    parameter int CNT_W    = 8
) (
    input logic                 clk,
    input logic                 rst_n,
    shift_arbiter_4bit_if.slave bus
);
    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [0:0]       state;
    logic             rr_ptr;
    logic [3:0]       out_data_q;
    logic             out_id_q;
    logic [CNT_W-1:0] cnt0_q;
    logic [CNT_W-1:0] cnt1_q;

    logic free;
    logic gnt0;
    logic gnt1;
    logic acc0;
    logic acc1;
    logic drain;

    function automatic logic [3:0] shift_op(input logic [3:0] a, input logic [3:0] b,
                                            input logic [1:0] sel);
        logic big;
        big = (b[3:2] != 2'b00);
        case (sel)
            2'b00:   shift_op = big ? 4'b0000 : (a << b[1:0]);
            2'b01:   shift_op = big ? 4'b0000 : (a >> b[1:0]);
            2'b10:   shift_op = big ? {4{a[3]}} : 4'($signed(a) >>> b[1:0]);
            default: shift_op = a;
        endcase
    endfunction

    assign free  = (state == ST_EMPTY) || bus.out_ready;
    assign drain = (state == ST_FULL) && bus.out_ready;

    // Port 1 wins only when port 0 is idle or it is port 1's round-robin turn.
    assign gnt1 = bus.req1_valid && (!bus.req0_valid || ((ARB_MODE == 0) && rr_ptr));
    assign gnt0 = bus.req0_valid && !gnt1;
    assign acc0 = gnt0 && free && rst_n;
    assign acc1 = gnt1 && free && rst_n;

    assign bus.req0_ready = acc0;
    assign bus.req1_ready = acc1;
    assign bus.out_valid  = (state == ST_FULL);
    assign bus.out_data   = out_data_q;
    assign bus.out_id     = out_id_q;
    assign bus.cnt0       = cnt0_q;
    assign bus.cnt1       = cnt1_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_EMPTY;
            rr_ptr     <= 1'b0;
            out_data_q <= 4'b0000;
            out_id_q   <= 1'b0;
            cnt0_q     <= '0;
            cnt1_q     <= '0;
        end else begin
            if (acc0) begin
                state      <= ST_FULL;
                out_data_q <= shift_op(bus.req0_a, bus.req0_b, bus.req0_sel);
                out_id_q   <= 1'b0;
                if (ARB_MODE == 0) rr_ptr <= 1'b1;
            end else if (acc1) begin
                state      <= ST_FULL;
                out_data_q <= shift_op(bus.req1_a, bus.req1_b, bus.req1_sel);
                out_id_q   <= 1'b1;
                if (ARB_MODE == 0) rr_ptr <= 1'b0;
            end else if (drain) begin
                state <= ST_EMPTY;
            end

            // Counters saturate so a long-running port cannot alias back to zero.
            if (drain && !out_id_q && (cnt0_q != {CNT_W{1'b1}}))
                cnt0_q <= cnt0_q + {{(CNT_W-1){1'b0}}, 1'b1};
            if (drain && out_id_q && (cnt1_q != {CNT_W{1'b1}}))
                cnt1_q <= cnt1_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end
endmodule

// File: tb/tb_shift_arbiter_4bit.sv
// Directed bench: three instances (round-robin, fixed priority, 2-bit counters) share one stimulus.
module tb_shift_arbiter_4bit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic       req0_valid = 1'b0;
    logic [3:0] req0_a = 4'd0;
    logic [3:0] req0_b = 4'd0;
    logic [1:0] req0_sel = 2'd0;
    logic       req1_valid = 1'b0;
    logic [3:0] req1_a = 4'd0;
    logic [3:0] req1_b = 4'd0;
    logic [1:0] req1_sel = 2'd0;
    logic       out_ready = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    shift_arbiter_4bit_if #(.CNT_W(8)) ifa ();
    shift_arbiter_4bit_if #(.CNT_W(8)) ifb ();
    shift_arbiter_4bit_if #(.CNT_W(2)) ifc ();

    assign ifa.req0_valid = req0_valid;  assign ifb.req0_valid = req0_valid;  assign ifc.req0_valid = req0_valid;
    assign ifa.req0_a     = req0_a;      assign ifb.req0_a     = req0_a;      assign ifc.req0_a     = req0_a;
    assign ifa.req0_b     = req0_b;      assign ifb.req0_b     = req0_b;      assign ifc.req0_b     = req0_b;
    assign ifa.req0_sel   = req0_sel;    assign ifb.req0_sel   = req0_sel;    assign ifc.req0_sel   = req0_sel;
    assign ifa.req1_valid = req1_valid;  assign ifb.req1_valid = req1_valid;  assign ifc.req1_valid = req1_valid;
    assign ifa.req1_a     = req1_a;      assign ifb.req1_a     = req1_a;      assign ifc.req1_a     = req1_a;
    assign ifa.req1_b     = req1_b;      assign ifb.req1_b     = req1_b;      assign ifc.req1_b     = req1_b;
    assign ifa.req1_sel   = req1_sel;    assign ifb.req1_sel   = req1_sel;    assign ifc.req1_sel   = req1_sel;
    assign ifa.out_ready  = out_ready;   assign ifb.out_ready  = out_ready;   assign ifc.out_ready  = out_ready;

    shift_arbiter_4bit #(.ARB_MODE(0), .CNT_W(8)) dut_rr  (.clk(clk), .rst_n(rst_n), .bus(ifa));
    shift_arbiter_4bit #(.ARB_MODE(1), .CNT_W(8)) dut_fix (.clk(clk), .rst_n(rst_n), .bus(ifb));
    shift_arbiter_4bit #(.ARB_MODE(0), .CNT_W(2)) dut_sat (.clk(clk), .rst_n(rst_n), .bus(ifc));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        tick();
        n_cmp++; if (ifa.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", ifa.out_valid); end
        n_cmp++; if (ifa.out_data !== 4'b0000) begin n_err++; $display("FAIL reset_out_data got %b want 0000", ifa.out_data); end
        n_cmp++; if (ifa.out_id !== 1'b0) begin n_err++; $display("FAIL reset_out_id got %b want 0", ifa.out_id); end
        n_cmp++; if (ifa.cnt0 !== 8'd0 || ifa.cnt1 !== 8'd0) begin n_err++; $display("FAIL reset_cnt got %0d/%0d want 0/0", ifa.cnt0, ifa.cnt1); end
        n_cmp++; if (ifa.req0_ready !== 1'b0 || ifa.req1_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready got %b%b want 00", ifa.req0_ready, ifa.req1_ready); end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        apply_reset();
        out_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 4'b1011; req0_b = 4'd1; req0_sel = 2'b01;
        #1;
        n_cmp++; if (ifa.req0_ready !== 1'b1) begin n_err++; $display("FAIL basic_ready got %b want 1", ifa.req0_ready); end
        tick();
        req0_valid = 1'b0;
        n_cmp++; if (ifa.out_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid got %b want 1", ifa.out_valid); end
        n_cmp++; if (ifa.out_data !== 4'b0101) begin n_err++; $display("FAIL basic_data got %b want 0101", ifa.out_data); end
        n_cmp++; if (ifa.out_id !== 1'b0) begin n_err++; $display("FAIL basic_id got %b want 0", ifa.out_id); end
        tick();
        n_cmp++; if (ifa.cnt0 !== 8'd1) begin n_err++; $display("FAIL basic_cnt0 got %0d want 1", ifa.cnt0); end
        n_cmp++; if (ifa.out_valid !== 1'b0) begin n_err++; $display("FAIL basic_drained got %b want 0", ifa.out_valid); end
    endtask

    task automatic test_contention();
        logic exp_id;
        apply_reset();
        out_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 4'b0001; req0_b = 4'd1; req0_sel = 2'b00;
        req1_valid = 1'b1; req1_a = 4'b1000; req1_b = 4'd1; req1_sel = 2'b01;
        for (int i = 0; i < 4; i++) begin
            exp_id = i[0];
            #1;
            n_cmp++; if (ifa.req0_ready !== !exp_id || ifa.req1_ready !== exp_id) begin n_err++; $display("FAIL rr_grant[%0d] got %b%b want %b%b", i, ifa.req0_ready, ifa.req1_ready, !exp_id, exp_id); end
            n_cmp++; if (ifb.req0_ready !== 1'b1 || ifb.req1_ready !== 1'b0) begin n_err++; $display("FAIL fix_grant[%0d] got %b%b want 10", i, ifb.req0_ready, ifb.req1_ready); end
            tick();
            n_cmp++; if (ifa.out_valid !== 1'b1 || ifa.out_id !== exp_id || ifa.out_data !== (exp_id ? 4'b0100 : 4'b0010)) begin
                n_err++; $display("FAIL rr_result[%0d] got v=%b id=%b d=%b want v=1 id=%b d=%b", i, ifa.out_valid, ifa.out_id, ifa.out_data, exp_id, exp_id ? 4'b0100 : 4'b0010);
            end
            n_cmp++; if (ifb.out_id !== 1'b0 || ifb.out_data !== 4'b0010) begin n_err++; $display("FAIL fix_result[%0d] got id=%b d=%b want id=0 d=0010", i, ifb.out_id, ifb.out_data); end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
        n_cmp++; if (ifa.cnt0 !== 8'd2 || ifa.cnt1 !== 8'd2) begin n_err++; $display("FAIL rr_counts got %0d/%0d want 2/2", ifa.cnt0, ifa.cnt1); end
        n_cmp++; if (ifb.cnt0 !== 8'd4 || ifb.cnt1 !== 8'd0) begin n_err++; $display("FAIL fix_counts got %0d/%0d want 4/0", ifb.cnt0, ifb.cnt1); end
    endtask

    task automatic test_backpressure();
        apply_reset();
        out_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 4'b0001; req0_b = 4'd3; req0_sel = 2'b00;
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_a = 4'b0110; req1_b = 4'd2; req1_sel = 2'b10;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_cmp++; if (ifa.req1_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready[%0d] got %b want 0", i, ifa.req1_ready); end
            tick();
            n_cmp++; if (ifa.out_valid !== 1'b1 || ifa.out_data !== 4'b1000 || ifa.out_id !== 1'b0) begin
                n_err++; $display("FAIL bp_hold[%0d] got v=%b d=%b id=%b want v=1 d=1000 id=0", i, ifa.out_valid, ifa.out_data, ifa.out_id);
            end
        end
        out_ready = 1'b1;
        #1;
        n_cmp++; if (ifa.req1_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_ready got %b want 1", ifa.req1_ready); end
        tick();
        req1_valid = 1'b0;
        n_cmp++; if (ifa.out_data !== 4'b0001 || ifa.out_id !== 1'b1 || ifa.cnt0 !== 8'd1) begin
            n_err++; $display("FAIL bp_next got d=%b id=%b cnt0=%0d want d=0001 id=1 cnt0=1", ifa.out_data, ifa.out_id, ifa.cnt0);
        end
        tick();
        n_cmp++; if (ifa.cnt1 !== 8'd1 || ifa.out_valid !== 1'b0) begin n_err++; $display("FAIL bp_drain got cnt1=%0d v=%b want cnt1=1 v=0", ifa.cnt1, ifa.out_valid); end
    endtask

    task automatic test_boundary();
        logic [13:0] vec [10];
        logic [3:0]  exp_d;
        //            a        b      sel    expected
        vec[0] = {4'b1001, 4'd4,  2'b00, 4'b0000};
        vec[1] = {4'b1001, 4'd15, 2'b00, 4'b0000};
        vec[2] = {4'b1001, 4'd4,  2'b01, 4'b0000};
        vec[3] = {4'b1001, 4'd15, 2'b01, 4'b0000};
        vec[4] = {4'b1001, 4'd4,  2'b10, 4'b1111};
        vec[5] = {4'b1001, 4'd15, 2'b10, 4'b1111};
        vec[6] = {4'b0110, 4'd2,  2'b10, 4'b0001};
        vec[7] = {4'b0110, 4'd2,  2'b11, 4'b0110};
        vec[8] = {4'b1011, 4'd2,  2'b00, 4'b1100};
        vec[9] = {4'b1011, 4'd1,  2'b10, 4'b1101};
        apply_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            req0_valid = 1'b1;
            req0_a   = vec[i][13:10];
            req0_b   = vec[i][9:6];
            req0_sel = vec[i][5:4];
            exp_d    = vec[i][3:0];
            tick();
            n_cmp++; if (ifa.out_valid !== 1'b1 || ifa.out_data !== exp_d) begin
                n_err++; $display("FAIL shift[%0d] a=%b b=%0d sel=%b got v=%b d=%b want v=1 d=%b", i, req0_a, req0_b, req0_sel, ifa.out_valid, ifa.out_data, exp_d);
            end
        end
        req0_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        apply_reset();
        out_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 4'b0011; req0_b = 4'd0; req0_sel = 2'b11;
        tick();
        tick();
        req0_valid = 1'b0;
        out_ready = 1'b0;
        tick();
        n_cmp++; if (ifa.out_valid !== 1'b1 || ifa.cnt0 !== 8'd1) begin n_err++; $display("FAIL rmid_pre got v=%b cnt0=%0d want v=1 cnt0=1", ifa.out_valid, ifa.cnt0); end
        rst_n = 1'b0;
        tick();
        n_cmp++; if (ifa.out_valid !== 1'b0 || ifa.cnt0 !== 8'd0 || ifa.cnt1 !== 8'd0) begin
            n_err++; $display("FAIL rmid_post got v=%b cnt=%0d/%0d want v=0 cnt=0/0", ifa.out_valid, ifa.cnt0, ifa.cnt1);
        end
        rst_n = 1'b1;
        out_ready = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        n_cmp++; if (ifa.req0_ready !== 1'b1 || ifa.req1_ready !== 1'b0) begin n_err++; $display("FAIL rmid_ptr got %b%b want 10", ifa.req0_ready, ifa.req1_ready); end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
    endtask

    task automatic test_saturate();
        apply_reset();
        out_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 4'b0101; req0_b = 4'd0; req0_sel = 2'b00;
        for (int i = 0; i < 5; i++) tick();
        req0_valid = 1'b0;
        tick();
        n_cmp++; if (ifc.cnt0 !== 2'd3) begin n_err++; $display("FAIL sat_cnt0 got %0d want 3", ifc.cnt0); end
        n_cmp++; if (ifa.cnt0 !== 8'd5) begin n_err++; $display("FAIL wide_cnt0 got %0d want 5", ifa.cnt0); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_contention();
        test_backpressure();
        test_boundary();
        test_reset_mid();
        test_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/shift_arbiter_4bit.md
Name: shift_arbiter_4bit

Overview:
- Round-robin arbiter and sequencer that shares one 4-bit left/right/arithmetic shift datapath between two requesters (ALU control port 0, test/debug port 1).
- Accepts one request per cycle through valid/ready handshakes and registers the shift result in a single-entry output stage.
- Returns the result with the requester ID under output backpressure, and keeps per-port completed-operation counters.

Parameters:
ARB_MODE, 0, 0 = round-robin between ports, 1 = fixed priority (port 0 always wins)
CNT_W, 8, width of per-port completed-operation counters (saturating)

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
req0_valid  input  1  port 0 request valid
req0_ready  output  1  port 0 request accepted when valid&&ready
req0_a  input  4  port 0 operand to be shifted
req0_b  input  4  port 0 shift amount (unsigned 0..15)
req0_sel  input  2  port 0 op: 00 left, 01 logical right, 10 arithmetic right, 11 pass-through
req1_valid  input  1  port 1 request valid
req1_ready  output  1  port 1 accept
req1_a  input  4  port 1 operand
req1_b  input  4  port 1 shift amount
req1_sel  input  2  port 1 op
out_valid  output  1  result register holds valid data
out_ready  input  1  consumer accepts result
out_data  output  4  shift result
out_id  output  1  ID of the port whose request produced out_data
cnt0  output  CNT_W  port 0 completed results (out handshake with out_id=0)
cnt1  output  CNT_W  port 1 completed results

Behaviour:
- Reset (rst_n=0 at a clk edge): out_valid=0, out_data=0, out_id=0, cnt0=cnt1=0, rr pointer=0 (port 0 preferred), req0_ready=req1_ready=0 during reset. Reset mid-operation discards any held result without handshake.
- Slot free: free = !out_valid || out_ready. No request is accepted unless free.
- Grant (combinational):
  - Only one port granted per cycle; reqN_ready=1 only for the granted port, and only while free.
  - A port with valid=0 is never granted. If one port is valid, it wins.
  - If both are valid: ARB_MODE=0 grants the port indicated by rr pointer; ARB_MODE=1 grants port 0.
- Pointer update: on accepted request from port N with ARB_MODE=0, pointer <= ~N. Pointer is unchanged when nothing is accepted. Result: strict alternation under continuous contention.
- Execute:
  - On acceptance, out_data <= shift(a,b,sel), out_id <= N, out_valid <= 1 at the same edge. Latency is 1 cycle from accept edge to out_valid.
  - Simultaneous drain and accept (out_valid&&out_ready with a new accept) replaces the register. Full throughput is one op/cycle.
  - On out_valid&&out_ready with no new accept, out_valid <= 0.
- Shift rules (amount = unsigned b):
  - 00: a<<b, zero fill; b>=4 gives 0.
  - 01: a>>b, zero fill; b>=4 gives 0.
  - 10: arithmetic right, sign(a[3]) fill; b>=4 gives {4{a[3]}}.
  - 11: out = a.
- Holding: out_data and out_id are stable while out_valid=1 and out_ready=0. Requests stay pending; the requester must hold its valid and operands until ready.
- Counters: cntN increments on out_valid&&out_ready with out_id=N and saturates at 2^CNT_W-1 (no wrap).
- States: EMPTY (out_valid=0) and FULL (out_valid=1).
  - EMPTY→FULL on accept.
  - FULL→FULL on accept-with-drain or on stall.
  - FULL→EMPTY on drain without accept.

Test Plan:
- Reset then port0 {a=4'b1011,b=1,sel=01}, out_ready=1 -> req0_ready=1; next cycle out_valid=1, out_data=4'b0101, out_id=0; cnt0=1 after handshake.
- Both ports valid continuously, ARB_MODE=0, out_ready=1 -> grants alternate 0,1,0,1 from reset; out_id sequence 0,1,0,1; one result every cycle.
- Same stimulus with ARB_MODE=1 -> port 0 granted every cycle; req1_ready stays 0; cnt1 stays 0.
- out_ready=0 with result 4'b1000 held, port1 valid -> req1_ready=0, out_data holds 4'b1000 for 5 cycles; out_ready=1 -> same-cycle accept of port1, new result next cycle.
- Boundary shifts: a=4'b1001 with b=4, b=15 -> sel00: 0; sel01: 0; sel10: 4'b1111; a=4'b0110, sel10, b=2 -> 4'b0001; sel11 -> 4'b0110.
- rst_n low while out_valid=1 -> next cycle out_valid=0, cnt0=cnt1=0, rr pointer=0; CNT_W=2 with 5 port0 completions -> cnt0 saturates at 3.
